// File: rtl/accum_sched_arb_pkg.sv
// Shared types for the accumulator scheduler: FSM state encoding, default
// sum width and the requester-index width helper.
package accum_sched_arb_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int idw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_rr_pick.sv
// Combinational round-robin picker: the valid request closest at or after
// ptr_i (wrapping) wins; outputs one-hot and binary index.
module accum_rr_pick
  import accum_sched_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  int dist_s;
  int best_d_s;
  int best_k_s;

  always_comb begin
    dist_s   = 0;
    best_d_s = NREQ;
    best_k_s = 0;
    // Distance from the pointer decides priority; smallest distance wins.
    for (int k = 0; k < NREQ; k++) begin
      dist_s = (k + NREQ - int'(ptr_i)) % NREQ;
      if (req_i[k] && (dist_s < best_d_s)) begin
        best_d_s = dist_s;
        best_k_s = k;
      end
    end
    gnt_oh_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt_oh_o[k] = (|req_i) && (k == best_k_s);
    end
    gnt_idx_o = IDW'(best_k_s);
  end

endmodule

// File: rtl/accum_sched_arb.sv
// Round-robin scheduler sharing one reduction engine among NREQ requesters,
// one job in flight. Optional WAIT watchdog under macro ACCUM_SCHED_WDOG_EN.
module accum_sched_arb
  import accum_sched_arb_pkg::*;
#(
  parameter  int DW       = DW_DEF,
  parameter  int NREQ     = 2,
  parameter  int WDOG_CYC = 300,
  localparam int IDW      = idw_f(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] req_ready_o,
  output logic            eng_start_o,
  output logic [IDW-1:0]  eng_sel_o,
  input  logic            eng_done_i,
  input  logic [DW-1:0]   eng_sum_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [IDW-1:0]  resp_id_o,
  output logic [DW-1:0]   resp_sum_o,
  output logic            resp_err_o,
  output logic            busy_o,
  output logic            stray_done_o
);

  state_e          state_q;
  logic [IDW-1:0]  rr_q;
  logic [IDW-1:0]  grant_q;
  logic            eng_start_q;
  logic [IDW-1:0]  eng_sel_q;
  logic            busy_q;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [DW-1:0]   resp_sum_q;
  logic            stray_q;
  logic [NREQ-1:0] pick_oh_s;
  logic [IDW-1:0]  pick_idx_s;

`ifdef ACCUM_SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wdog_q;
  logic          resp_err_q;
  assign resp_err_o = resp_err_q;
`else
  logic wdog_unused_s;
  assign wdog_unused_s = (WDOG_CYC != 0);
  assign resp_err_o    = 1'b0;
`endif

  accum_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (rr_q),
    .gnt_oh_o  (pick_oh_s),
    .gnt_idx_o (pick_idx_s)
  );

  // Acceptance is same-cycle, so the ready pulse decodes the live requests.
  assign req_ready_o  = ((state_q == ST_IDLE) && !rst) ? pick_oh_s : '0;
  assign eng_start_o  = eng_start_q;
  assign eng_sel_o    = eng_sel_q;
  assign busy_o       = busy_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_sum_o   = resp_sum_q;
  assign stray_done_o = stray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      eng_start_q  <= 1'b0;
      eng_sel_q    <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      stray_q      <= 1'b0;
`ifdef ACCUM_SCHED_WDOG_EN
      wdog_q       <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      if (eng_done_i && (state_q != ST_WAIT)) stray_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            grant_q     <= pick_idx_s;
            eng_sel_q   <= pick_idx_s;
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          eng_start_q <= 1'b0;
          state_q     <= ST_WAIT;
`ifdef ACCUM_SCHED_WDOG_EN
          wdog_q      <= '0;
`endif
        end
        ST_WAIT: begin
          if (eng_done_i) begin
            resp_sum_q   <= eng_sum_i;
            resp_id_q    <= grant_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
`ifdef ACCUM_SCHED_WDOG_EN
            resp_err_q   <= 1'b0;
          end else if (wdog_q == CW'(WDOG_CYC - 1)) begin
            resp_sum_q   <= '0;
            resp_id_q    <= grant_q;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + CW'(1);
`endif
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            eng_sel_q    <= '0;
            state_q      <= ST_IDLE;
            rr_q         <= (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sched_arb.sv
// Bench for accum_sched_arb: directed job table, stray/watchdog/reset
// sequences and a randomized run against a transaction-level model.
module tb_accum_sched_arb;

  localparam int DW = 16;
  localparam int NREQ = 2;
  localparam int IDW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid_i = '0;
  logic [NREQ-1:0] req_ready_o;
  logic            eng_start_o;
  logic [IDW-1:0]  eng_sel_o;
  logic            eng_done_i = 1'b0;
  logic [DW-1:0]   eng_sum_i = '0;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b0;
  logic [IDW-1:0]  resp_id_o;
  logic [DW-1:0]   resp_sum_o;
  logic            resp_err_o;
  logic            busy_o;
  logic            stray_done_o;

  accum_sched_arb #(.DW(DW), .NREQ(NREQ), .WDOG_CYC(20)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .eng_start_o(eng_start_o), .eng_sel_o(eng_sel_o),
    .eng_done_i(eng_done_i), .eng_sum_i(eng_sum_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_sum_o(resp_sum_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .stray_done_o(stray_done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic start_job(input logic [1:0] v, input int exp_id);
    tick(); req_valid_i = v; smp();
    chk("accept_ready", {30'd0, req_ready_o}, 32'd1 << exp_id);
    chk("accept_nostart", {31'd0, eng_start_o}, 32'd0);
    tick(); req_valid_i = 2'b00; smp();
    chk("start_pulse", {31'd0, eng_start_o}, 32'd1);
    chk("start_sel", {31'd0, eng_sel_o}, exp_id);
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_noready", {30'd0, req_ready_o}, 32'd0);
  endtask

  task automatic run_job(input logic [1:0] v, input int dly, input logic [15:0] sum,
                         input int exp_id, input int bp);
    start_job(v, exp_id);
    for (int k = 1; k < dly; k++) begin
      tick(); smp();
      chk("wait_norv", {31'd0, resp_valid_o}, 32'd0);
    end
    tick(); eng_done_i = 1'b1; eng_sum_i = sum; smp();
    tick(); eng_done_i = 1'b0; eng_sum_i = 16'(~sum); smp();
    chk("resp_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("resp_id", {31'd0, resp_id_o}, exp_id);
    chk("resp_sum", {16'd0, resp_sum_o}, {16'd0, sum});
    chk("resp_err", {31'd0, resp_err_o}, 32'd0);
    for (int b = 0; b < bp; b++) begin
      tick(); req_valid_i = 2'b11; resp_ready_i = 1'b0; smp();
      chk("bp_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("bp_sum", {16'd0, resp_sum_o}, {16'd0, sum});
      chk("bp_id", {31'd0, resp_id_o}, exp_id);
      chk("bp_noready", {30'd0, req_ready_o}, 32'd0);
    end
    tick(); resp_ready_i = 1'b1; smp();
    chk("hs_noready", {30'd0, req_ready_o}, 32'd0);
    tick(); resp_ready_i = 1'b0; req_valid_i = 2'b00; smp();
    chk("post_idle_rv", {31'd0, resp_valid_o}, 32'd0);
    chk("post_idle_busy", {31'd0, busy_o}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  v;
    int          dly;
    logic [15:0] sum;
    int          exp_id;
    int          bp;
  } vec_t;

  vec_t tbl[10];

  // Transaction-level model state for the randomized phase.
  int          rr_m;
  bit          busy_m, pend_m, gen, rdy;
  int          start_c, done_c, id_m, win;
  logic [15:0] sum_m;
  logic [1:0]  vld, exp_rdy;

  initial begin
`ifdef ACCUM_SCHED_WDOG_EN
    tbl[0] = '{2'b01, 10, 16'h3C00, 0, 0};
`else
    tbl[0] = '{2'b01, 129, 16'h3C00, 0, 0};
`endif
    tbl[1] = '{2'b11, 3, 16'h1111, 1, 0};
    tbl[2] = '{2'b11, 4, 16'h2222, 0, 0};
    tbl[3] = '{2'b11, 5, 16'h3333, 1, 0};
    tbl[4] = '{2'b11, 6, 16'h4444, 0, 10};
    tbl[5] = '{2'b01, 2, 16'h5555, 0, 0};
    tbl[6] = '{2'b01, 1, 16'h6666, 0, 3};
    tbl[7] = '{2'b10, 7, 16'h7777, 1, 0};
    tbl[8] = '{2'b10, 2, 16'h8888, 1, 0};
    tbl[9] = '{2'b11, 15, 16'hFFFF, 0, 1};

    // Reset state.
    tick(); tick(); smp();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rvalid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_start", {31'd0, eng_start_o}, 32'd0);
    chk("rst_sum", {16'd0, resp_sum_o}, 32'd0);
    chk("rst_stray", {31'd0, stray_done_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_job(tbl[i].v, tbl[i].dly, tbl[i].sum, tbl[i].exp_id, tbl[i].bp);
    chk("no_stray_yet", {31'd0, stray_done_o}, 32'd0);

    // Stray done in IDLE: sticky flag, no response.
    tick(); eng_done_i = 1'b1; eng_sum_i = 16'hDEAD; smp();
    tick(); eng_done_i = 1'b0; smp();
    chk("stray_set", {31'd0, stray_done_o}, 32'd1);
    chk("stray_norv", {31'd0, resp_valid_o}, 32'd0);
    chk("stray_nobusy", {31'd0, busy_o}, 32'd0);

    // Randomized run; rr pointer is 1 after the table.
    rr_m = 1; busy_m = 0; pend_m = 0; start_c = -1; done_c = -1; id_m = 0;
    sum_m = '0; vld = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      gen = (cyc < 1200);
      if (!gen) vld = '0;
      tick();
      req_valid_i  = vld;
      eng_done_i   = (cyc == done_c);
      eng_sum_i    = 16'($urandom);
      rdy          = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
      resp_ready_i = rdy;
      smp();
      win = -1;
      if (!busy_m)
        for (int i = 0; i < NREQ; i++)
          if (win < 0 && vld[(rr_m + i) % NREQ]) win = (rr_m + i) % NREQ;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("rnd_ready", {30'd0, req_ready_o}, {30'd0, exp_rdy});
      chk("rnd_start", {31'd0, eng_start_o}, {31'd0, cyc == start_c});
      chk("rnd_rvalid", {31'd0, resp_valid_o}, {31'd0, pend_m});
      if (pend_m && rdy) begin
        chk("rnd_id", {31'd0, resp_id_o}, id_m);
        chk("rnd_sum", {16'd0, resp_sum_o}, {16'd0, sum_m});
        chk("rnd_err", {31'd0, resp_err_o}, 32'd0);
        pend_m = 0; busy_m = 0; rr_m = (id_m + 1) % NREQ;
      end
      if (win >= 0) begin
        busy_m = 1; id_m = win; start_c = cyc + 1; vld[win] = 1'b0;
      end
      if (cyc == start_c) done_c = cyc + $urandom_range(1, 15);
      if (cyc == done_c) begin
        pend_m = 1; sum_m = eng_sum_i;
      end
      if (gen)
        for (int i = 0; i < NREQ; i++) begin
          if (!vld[i]) vld[i] = ($urandom_range(0, 3) == 0);
          else if ($urandom_range(0, 15) == 0) vld[i] = 1'b0;
        end
    end
    tick(); eng_done_i = 1'b0; resp_ready_i = 1'b0; req_valid_i = '0; smp();
    chk("rnd_drained", {31'd0, busy_o}, {31'd0, busy_m});
    chk("stray_sticky", {31'd0, stray_done_o}, 32'd1);

    // No done: watchdog response, or FSM held in WAIT.
    start_job(2'b11, rr_m);
`ifdef ACCUM_SCHED_WDOG_EN
    for (int k = 1; k <= 20; k++) begin
      tick(); smp();
      chk("wdog_wait", {31'd0, resp_valid_o}, 32'd0);
    end
    tick(); smp();
    chk("wdog_rvalid", {31'd0, resp_valid_o}, 32'd1);
    chk("wdog_err", {31'd0, resp_err_o}, 32'd1);
    chk("wdog_sum", {16'd0, resp_sum_o}, 32'd0);
    chk("wdog_id", {31'd0, resp_id_o}, rr_m);
    tick(); resp_ready_i = 1'b1; smp();
    tick(); resp_ready_i = 1'b0; eng_done_i = 1'b1; smp();
    tick(); eng_done_i = 1'b0; smp();
    chk("wdog_late_norv", {31'd0, resp_valid_o}, 32'd0);
    chk("wdog_late_idle", {31'd0, busy_o}, 32'd0);
    start_job(2'b11, (rr_m + 1) % NREQ);
    for (int k = 0; k < 5; k++) begin
      tick(); smp();
    end
`else
    for (int k = 0; k < 60; k++) begin
      tick(); smp();
      chk("hold_wait_rv", {31'd0, resp_valid_o}, 32'd0);
      chk("hold_wait_busy", {31'd0, busy_o}, 32'd1);
    end
`endif

    // Reset in WAIT: everything clears immediately, next grant is fresh.
    tick(); rst = 1'b1; #1;
    chk("rstw_busy", {31'd0, busy_o}, 32'd0);
    chk("rstw_sel", {31'd0, eng_sel_o}, 32'd0);
    chk("rstw_rvalid", {31'd0, resp_valid_o}, 32'd0);
    chk("rstw_stray", {31'd0, stray_done_o}, 32'd0);
    chk("rstw_err", {31'd0, resp_err_o}, 32'd0);
    tick(); tick(); rst = 1'b0;
    run_job(2'b11, 3, 16'hABCD, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
